// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cache line-fill controller: FSM encoding, default
// memory latency and the line-offset width helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StFill      = 2'd2,
    StRespond   = 2'd3
  } mem_ctrl_state_e;

  localparam int unsigned MemLatencyDefault = 5;

  // Number of byte-offset bits inside one line.
  function automatic int unsigned line_offset_width(input int unsigned line_size);
    return $clog2(line_size / 8);
  endfunction

  localparam int unsigned LineOffsetWidth = line_offset_width(128);

endpackage

// File: rtl/mem_wait_counter.sv
// Load / count-down timer that measures how long a memory strobe is held.
// done_o is high while the count is zero; the count saturates there.
module mem_wait_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/mem_line_controller.sv
// Cache miss handler: optionally writes back a dirty victim line, then fills the
// requested line from memory and returns it with a one-cycle response pulse.
module mem_line_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_SIZE     = 128,
  parameter int unsigned MEM_LATENCY   = MemLatencyDefault
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     req_wb,
  input  logic [ADDRESS_WIDTH-1:0] req_wb_addr,
  input  logic [LINE_SIZE-1:0]     req_wb_data,
  output logic                     resp_valid,
  output logic [ADDRESS_WIDTH-1:0] resp_addr,
  output logic [LINE_SIZE-1:0]     resp_data,
  output logic                     mem_read_enable,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [LINE_SIZE-1:0]     mem_data_in,
  input  logic [LINE_SIZE-1:0]     mem_data_out
);

  localparam int unsigned OffW = line_offset_width(LINE_SIZE);
  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam logic [ADDRESS_WIDTH-1:0] AlignMask = {ADDRESS_WIDTH{1'b1}} << OffW;
  // Loaded on state entry; the state is left on the cycle the count reads zero.
  localparam logic [CntW-1:0] WaitLoad = CntW'(MEM_LATENCY - 1);

  mem_ctrl_state_e state_d, state_q;

  logic                     req_ready_d, req_ready_q;
  logic                     resp_valid_d, resp_valid_q;
  logic [ADDRESS_WIDTH-1:0] resp_addr_d, resp_addr_q;
  logic [LINE_SIZE-1:0]     resp_data_d, resp_data_q;
  logic                     rd_en_d, rd_en_q;
  logic                     wr_en_d, wr_en_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_d, mem_addr_q;
  logic [LINE_SIZE-1:0]     mem_wdata_d, mem_wdata_q;
  logic [ADDRESS_WIDTH-1:0] fill_addr_d, fill_addr_q;

  logic handshake;
  logic cnt_load, cnt_en, cnt_done;

  assign handshake = req_valid && req_ready_q;
  assign cnt_en    = (state_q == StWriteback) || (state_q == StFill);

  mem_wait_counter #(
    .Width (CntW)
  ) u_wait_counter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (cnt_load),
    .load_value_i (WaitLoad),
    .en_i         (cnt_en),
    .done_o       (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_addr_d  = fill_addr_q;
    cnt_load     = 1'b0;

    case (state_q)
      StIdle: begin
        if (handshake) begin
          req_ready_d = 1'b0;
          fill_addr_d = req_addr & AlignMask;
          cnt_load    = 1'b1;
          if (req_wb) begin
            state_d     = StWriteback;
            wr_en_d     = 1'b1;
            mem_addr_d  = req_wb_addr & AlignMask;
            mem_wdata_d = req_wb_data;
          end else begin
            state_d    = StFill;
            rd_en_d    = 1'b1;
            mem_addr_d = req_addr & AlignMask;
          end
        end
      end
      StWriteback: begin
        if (cnt_done) begin
          state_d     = StFill;
          wr_en_d     = 1'b0;
          rd_en_d     = 1'b1;
          mem_addr_d  = fill_addr_q;
          mem_wdata_d = '0;
          cnt_load    = 1'b1;
        end
      end
      StFill: begin
        if (cnt_done) begin
          state_d      = StRespond;
          rd_en_d      = 1'b0;
          mem_addr_d   = '0;
          resp_valid_d = 1'b1;
          resp_addr_d  = fill_addr_q;
          resp_data_d  = mem_data_out;
        end
      end
      StRespond: begin
        state_d      = StIdle;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_addr_q  <= fill_addr_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_addr        = resp_addr_q;
  assign resp_data        = resp_data_q;
  assign mem_read_enable  = rd_en_q;
  assign mem_write_enable = wr_en_q;
  assign mem_address      = mem_addr_q;
  assign mem_data_in      = mem_wdata_q;

endmodule

// File: tb/tb_mem_line_controller.sv
// Directed bench for mem_line_controller: a MEM_LATENCY=5 instance and a
// MEM_LATENCY=1 instance share stimulus; sel routes req_valid and observation.
module tb_mem_line_controller;

  localparam int AW = 32;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          sel;
  logic          req_valid, req_wb;
  logic [AW-1:0] req_addr, req_wb_addr;
  logic [LW-1:0] req_wb_data, mem_rd_line;

  logic          rdy_a, rv_a, re_a, we_a, rdy_b, rv_b, re_b, we_b;
  logic [AW-1:0] ra_a, ma_a, ra_b, ma_b;
  logic [LW-1:0] rd_a, md_a, rd_b, md_b;

  logic          rdy, rv, re, we;
  logic [AW-1:0] ra, ma;
  logic [LW-1:0] rdat, mdin;

  assign rdy  = sel ? rdy_b : rdy_a;
  assign rv   = sel ? rv_b  : rv_a;
  assign re   = sel ? re_b  : re_a;
  assign we   = sel ? we_b  : we_a;
  assign ra   = sel ? ra_b  : ra_a;
  assign ma   = sel ? ma_b  : ma_a;
  assign rdat = sel ? rd_b  : rd_a;
  assign mdin = sel ? md_b  : md_a;

  mem_line_controller #(
    .ADDRESS_WIDTH (AW), .LINE_SIZE (LW), .MEM_LATENCY (5)
  ) u_dut_l5 (
    .clk (clk), .reset (reset),
    .req_valid (req_valid & ~sel), .req_ready (rdy_a),
    .req_addr (req_addr), .req_wb (req_wb),
    .req_wb_addr (req_wb_addr), .req_wb_data (req_wb_data),
    .resp_valid (rv_a), .resp_addr (ra_a), .resp_data (rd_a),
    .mem_read_enable (re_a), .mem_write_enable (we_a),
    .mem_address (ma_a), .mem_data_in (md_a), .mem_data_out (mem_rd_line)
  );

  mem_line_controller #(
    .ADDRESS_WIDTH (AW), .LINE_SIZE (LW), .MEM_LATENCY (1)
  ) u_dut_l1 (
    .clk (clk), .reset (reset),
    .req_valid (req_valid & sel), .req_ready (rdy_b),
    .req_addr (req_addr), .req_wb (req_wb),
    .req_wb_addr (req_wb_addr), .req_wb_data (req_wb_data),
    .resp_valid (rv_b), .resp_addr (ra_b), .resp_data (rd_b),
    .mem_read_enable (re_b), .mem_write_enable (we_b),
    .mem_address (ma_b), .mem_data_in (md_b), .mem_data_out (mem_rd_line)
  );

  int checks = 0;
  int errors = 0;

  // Per-transaction observations, cycle index 0 = cycle right after handshake edge.
  int            res_resp, res_rdy, n_rd, n_wr, n_ovl, addr_moved, rv_seen;
  logic [AW-1:0] rd_first, wr_first;
  logic [LW-1:0] mem_model [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic wb, input logic [AW-1:0] a, input logic [AW-1:0] wa,
                     input logic [LW-1:0] wd, input bit hold, input bit stray);
    @(negedge clk);
    req_wb      = wb;
    req_addr    = a;
    req_wb_addr = wa;
    req_wb_data = wd;
    req_valid   = 1'b1;
    chk("ready_before_handshake", rdy, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid   = hold;
    // Scramble inputs: the controller must work from its registered copies.
    req_addr    = 32'hDEAD_BEEF;
    req_wb_addr = 32'hCAFE_F00F;
    req_wb_data = '1;
    req_wb      = ~wb;
    res_resp = -1; res_rdy = -1; n_rd = 0; n_wr = 0; n_ovl = 0; addr_moved = 0;
    rd_first = '0; wr_first = '0;
    for (int i = 0; i < 40; i++) begin
      if (stray) req_valid = (i == 1);
      if (re) begin
        if (n_rd == 0) rd_first = ma;
        else if (ma !== rd_first) addr_moved++;
        n_rd++;
      end
      if (we) begin
        if (n_wr == 0) wr_first = ma;
        else if (ma !== wr_first) addr_moved++;
        n_wr++;
        mem_model[ma] = mdin;
      end
      if (re && we) n_ovl++;
      if (rv && res_resp < 0) res_resp = i;
      if (rdy) begin
        res_rdy = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_wb = 1'b0;
    req_addr = '0; req_wb_addr = '0; req_wb_data = '0; mem_rd_line = '0;
    #1;
    chk("rst_ready", rdy, 1);
    chk("rst_resp_valid", rv, 0);
    chk("rst_strobes", {re, we}, 0);
    chk("rst_mem_addr", ma, 0);
    chk("rst_resp_data", rdat, 0);
    chk("rst_ready_l1", rdy_b, 1);
    @(negedge clk);
    reset = 1'b0;

    // Clean miss, L=5
    mem_rd_line = {16{8'hA5}};
    txn(1'b0, 32'h0000_1234, 32'h0, '0, 1'b0, 1'b0);
    chk("clean_resp_cycle", res_resp, 5);
    chk("clean_ready_cycle", res_rdy, 6);
    chk("clean_rd_cycles", n_rd, 5);
    chk("clean_wr_cycles", n_wr, 0);
    chk("clean_rd_addr", rd_first, 32'h0000_1230);
    chk("clean_addr_stable", addr_moved, 0);
    chk("clean_resp_addr", ra, 32'h0000_1230);
    chk("clean_resp_data", rdat, {16{8'hA5}});
    chk("clean_mem_data_in_idle", mdin, 0);

    // Dirty miss with misaligned victim address, L=5
    mem_rd_line = {16{8'h3C}};
    txn(1'b1, 32'h0000_3010, 32'h0000_2007, {16{8'h11}}, 1'b0, 1'b0);
    chk("dirty_resp_cycle", res_resp, 10);
    chk("dirty_ready_cycle", res_rdy, 11);
    chk("dirty_wr_cycles", n_wr, 5);
    chk("dirty_rd_cycles", n_rd, 5);
    chk("dirty_wr_addr", wr_first, 32'h0000_2000);
    chk("dirty_rd_addr", rd_first, 32'h0000_3010);
    chk("dirty_overlap", n_ovl, 0);
    chk("dirty_addr_stable", addr_moved, 0);
    chk("dirty_mem_written", mem_model[32'h0000_2000], {16{8'h11}});
    chk("dirty_resp_addr", ra, 32'h0000_3010);
    chk("dirty_resp_data", rdat, {16{8'h3C}});

    // Stray req_valid pulse during FILL is ignored
    mem_rd_line = {16{8'h77}};
    txn(1'b0, 32'h0000_555F, 32'h0, '0, 1'b0, 1'b1);
    chk("stray_resp_cycle", res_resp, 5);
    chk("stray_resp_addr", ra, 32'h0000_5550);
    repeat (3) @(negedge clk);
    chk("stray_no_new_txn", {re, we, rdy}, 3'b001);

    // Back-to-back with req_valid held high
    mem_rd_line = {16{8'h99}};
    txn(1'b0, 32'h0000_0100, 32'h0, '0, 1'b1, 1'b0);
    chk("b2b_ready_cycle", res_rdy, 6);
    chk("b2b_first_overlap", n_ovl, 0);
    req_addr = 32'h0000_4444;
    req_wb   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_accepted", {re, we, rdy}, 3'b100);
    chk("b2b_second_addr", ma, 32'h0000_4440);
    rv_seen = 0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      if (rv) rv_seen++;
    end
    chk("b2b_second_done", {rdy, rv_seen[1:0]}, 3'b101);
    chk("b2b_second_resp_addr", ra, 32'h0000_4440);

    // Reset during the third FILL cycle aborts the transaction
    @(negedge clk);
    req_addr = 32'h0000_6660; req_wb = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_reading", re, 1);
    reset = 1'b1;
    #1;
    chk("abort_rd_drops", re, 0);
    chk("abort_ready", rdy, 1);
    chk("abort_mem_addr", ma, 0);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv || re || we) rv_seen++;
    end
    chk("abort_quiet", rv_seen, 0);
    chk("abort_ready_after", rdy, 1);

    // MEM_LATENCY=1 instance
    sel = 1'b1;
    mem_rd_line = {16{8'h5A}};
    txn(1'b0, 32'h0000_7778, 32'h0, '0, 1'b0, 1'b0);
    chk("l1_clean_resp_cycle", res_resp, 1);
    chk("l1_clean_rd_cycles", n_rd, 1);
    chk("l1_clean_resp", {ra, rdat}, {32'h0000_7770, {16{8'h5A}}});
    mem_rd_line = {16{8'hC3}};
    txn(1'b1, 32'h0000_9000, 32'h0000_8000, {16{8'h22}}, 1'b0, 1'b0);
    chk("l1_dirty_resp_cycle", res_resp, 2);
    chk("l1_dirty_ready_cycle", res_rdy, 3);
    chk("l1_dirty_strobes", {n_wr[3:0], n_rd[3:0], n_ovl[3:0]}, 12'h110);
    chk("l1_dirty_mem_written", mem_model[32'h0000_8000], {16{8'h22}});
    chk("l1_dirty_resp_data", rdat, {16{8'hC3}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
